// File: rtl/rv32i_types.sv
// rv32i_types: shared types and constants for the RV32I core front end.
//   fetch_state_t : instruction-fetch controller states
//   PC_RESET      : program counter value after reset
//   word_align()  : clears the two low address bits of a fetch target
package rv32i_types;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,  // read outstanding for the current PC
    HOLD    = 2'd1,  // instruction buffered while downstream is stalled
    DISCARD = 2'd2   // read outstanding for a squashed PC
  } fetch_state_t;

  localparam logic [31:0] PC_RESET = 32'h0000_0060;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// pc_reg: 32-bit program counter with synchronous reset to PC_RESET.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   load        : update the PC this cycle
//   sel_target  : 1 = load word-aligned target, 0 = load PC+4
//   target      : redirect target (low two bits ignored)
//   pc          : current PC
//   pc_plus4    : pc + 4 (mod 2^32)
module pc_reg
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        sel_target,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  assign pc_plus4 = pc + 32'd4;

  // PC register: sequential advance or aligned redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= PC_RESET;
    end else if (load) begin
      pc <= sel_target ? word_align(target) : pc_plus4;
    end else begin
      pc <= pc;
    end
  end

endmodule

// File: rtl/ifetch_stage.sv
// ifetch_stage: RV32I instruction-fetch stage. Owns the PC, runs the
// instruction-memory read handshake, buffers one instruction across a
// downstream stall and tracks redirects that land while a read is in flight.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   stall_in                 : IF/ID cannot accept this cycle
//   redirect, redirect_pc    : control transfer and its target
//   imem_address, imem_read  : memory request (address = current PC)
//   imem_rdata, imem_resp    : memory read data / single-cycle completion
//   instr_out, pc_out, pc_plus4_out, instr_valid : IF/ID payload
//   fetch_busy               : read outstanding with nothing usable
// Optional build macro IFETCH_PERF_CTR_EN adds perf_fetched / perf_squashed.
module ifetch_stage
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  output logic        instr_valid,
  output logic        fetch_busy
`ifdef IFETCH_PERF_CTR_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed
`endif
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_plus4;
  logic [31:0]  hold_buf;
  logic [31:0]  target, target_next;
  logic [31:0]  load_target;
  logic         pc_load, pc_sel_target, buf_load;

  pc_reg u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (pc_load),
    .sel_target (pc_sel_target),
    .target     (load_target),
    .pc         (pc),
    .pc_plus4   (pc_plus4)
  );

  assign imem_address = pc;
  assign imem_read    = !rst && (state != HOLD);
  assign pc_out       = pc;
  assign pc_plus4_out = pc_plus4;
  assign instr_out    = (state == HOLD) ? hold_buf : imem_rdata;
  assign instr_valid  = !rst && !redirect &&
                        (((state == FETCH) && imem_resp) || (state == HOLD));
  assign fetch_busy   = !rst &&
                        (((state == FETCH) && !imem_resp) || (state == DISCARD));

  // Next-state and PC-update decisions; redirect outranks stall everywhere.
  always_comb begin
    state_next    = state;
    pc_load       = 1'b0;
    pc_sel_target = 1'b0;
    load_target   = redirect_pc;
    target_next   = target;
    buf_load      = 1'b0;
    case (state)
      FETCH: begin
        if (redirect) begin
          if (imem_resp) begin
            pc_load       = 1'b1;
            pc_sel_target = 1'b1;
          end else begin
            // Address must stay put until the stale read completes.
            target_next = word_align(redirect_pc);
            state_next  = DISCARD;
          end
        end else if (imem_resp) begin
          if (stall_in) begin
            buf_load   = 1'b1;
            state_next = HOLD;
          end else begin
            pc_load = 1'b1;
          end
        end else begin
          state_next = FETCH;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_load       = 1'b1;
          pc_sel_target = 1'b1;
          state_next    = FETCH;
        end else if (!stall_in) begin
          pc_load    = 1'b1;
          state_next = FETCH;
        end else begin
          state_next = HOLD;
        end
      end
      DISCARD: begin
        if (imem_resp) begin
          // A redirect arriving with the stale response is the newest one.
          pc_load       = 1'b1;
          pc_sel_target = 1'b1;
          load_target   = redirect ? redirect_pc : target;
          state_next    = FETCH;
        end else if (redirect) begin
          target_next = word_align(redirect_pc);
        end else begin
          state_next = DISCARD;
        end
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // Controller state, hold buffer and latched redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      hold_buf <= 32'd0;
      target   <= 32'd0;
    end else begin
      state  <= state_next;
      target <= target_next;
      if (buf_load) begin
        hold_buf <= imem_rdata;
      end else begin
        hold_buf <= hold_buf;
      end
    end
  end

`ifdef IFETCH_PERF_CTR_EN
  logic accept, squash;

  assign accept = instr_valid && !stall_in;
  // Dropped response (redirected or stale) or dropped hold buffer.
  assign squash = !rst &&
                  ((imem_resp && (redirect || (state == DISCARD))) ||
                   ((state == HOLD) && redirect));

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched  <= 32'd0;
      perf_squashed <= 32'd0;
    end else begin
      perf_fetched  <= perf_fetched + {31'd0, accept};
      perf_squashed <= perf_squashed + {31'd0, squash};
    end
  end
`endif

endmodule
